// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : Fetch stage downstream of the 8-bit program counter. Holds
//                an internal instruction memory and presents fetched words
//                to decode through a valid/ready register. It steers the
//                counter (hold / redirect / increment), and handles program
//                load, start/halt control and an accepted-instruction count.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
   parameter int                 INSTR_W    = 9,
   parameter int                 DEPTH      = 256,
   parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         pc,
   output logic [7:0]         pc_control,
   output logic [7:0]         jump_offset,
   input  logic               start,
   input  logic               prog_we,
   input  logic [7:0]         prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   output logic [INSTR_W-1:0] instr,
   output logic [7:0]         instr_pc,
   output logic               instr_valid,
   input  logic               decode_ready,
   input  logic               branch_taken,
   input  logic [7:0]         branch_offset,
   output logic               running,
   output logic [15:0]        accepted_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [INSTR_W-1:0] r_mem [DEPTH];
   logic [INSTR_W-1:0] r_instr;
   logic [INSTR_W-1:0] w_instr_nxt;
   logic [7:0]         r_instr_pc;
   logic [7:0]         w_instr_pc_nxt;
   logic               r_valid;
   logic               w_valid_nxt;
   logic [15:0]        r_count;
   logic [7:0]         w_pc_control;
   logic [7:0]         w_jump_offset;
   logic [INSTR_W-1:0] w_rd_data;
   logic               w_accept;

   assign w_accept  = r_valid & decode_ready;
   assign w_rd_data = r_mem[pc];

   // Program load port; the fetch read sees the old word until the next cycle.
   always_ff @(posedge clk) begin
      if (prog_we && (r_state != ST_RUN)) begin
         r_mem[prog_addr] <= prog_data;
      end
   end

   // State and instruction register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_valid    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_instr    <= w_instr_nxt;
         r_instr_pc <= w_instr_pc_nxt;
         r_valid    <= w_valid_nxt;
      end
   end

   // Next state, instruction register update and counter steering.
   // Hold is expressed as pc + 1 + 8'hFF, so the counter needs no hold input.
   always_comb begin
      w_state_nxt    = r_state;
      w_instr_nxt    = r_instr;
      w_instr_pc_nxt = r_instr_pc;
      w_valid_nxt    = r_valid;
      w_pc_control   = 8'hFF;
      w_jump_offset  = 8'hFF;
      case (r_state)
         ST_RUN: begin
            if (w_accept && branch_taken) begin
               // target - pc - 1 = (instr_pc + 1 + off) - pc - 1
               w_jump_offset = r_instr_pc + branch_offset - pc;
               w_valid_nxt   = 1'b0;
            end else if (w_accept && (r_instr == HALT_INSTR)) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = ST_HALT;
            end else if (r_valid && !decode_ready) begin
               // Stall: hold counter and instruction register.
               w_valid_nxt = r_valid;
            end else begin
               w_pc_control   = 8'h00;
               w_instr_nxt    = w_rd_data;
               w_instr_pc_nxt = pc;
               w_valid_nxt    = 1'b1;
            end
         end
         default: begin
            w_valid_nxt = 1'b0;
            if (start) begin
               w_state_nxt = ST_RUN;
            end
         end
      endcase
   end

   // Saturating count of instructions accepted by decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (w_accept && (r_count != 16'hFFFF)) begin
         r_count <= r_count + 16'd1;
      end
   end

   assign pc_control     = w_pc_control;
   assign jump_offset    = w_jump_offset;
   assign instr          = r_instr;
   assign instr_pc       = r_instr_pc;
   assign instr_valid    = r_valid;
   assign running        = (r_state == ST_RUN);
   assign accepted_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Self-checking bench for instruction_fetch with a behavioural
//                program_counter and an accepted-instruction scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] pc;
   logic [7:0] pc_control;
   logic [7:0] jump_offset;
   logic       start = 1'b0;
   logic       prog_we = 1'b0;
   logic [7:0] prog_addr = '0;
   logic [8:0] prog_data = '0;
   logic [8:0] instr;
   logic [7:0] instr_pc;
   logic       instr_valid;
   logic       decode_ready = 1'b0;
   logic       branch_taken = 1'b0;
   logic [7:0] branch_offset = '0;
   logic       running;
   logic [15:0] accepted_count;

   int checks = 0;
   int errors = 0;

   // Scoreboard entries are {instr_pc, instr}.
   logic [16:0] sb[$];

   bit         pc_load = 1'b0;
   logic [7:0] pc_load_val = '0;

   instruction_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc             (pc),
      .pc_control     (pc_control),
      .jump_offset    (jump_offset),
      .start          (start),
      .prog_we        (prog_we),
      .prog_addr      (prog_addr),
      .prog_data      (prog_data),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .decode_ready   (decode_ready),
      .branch_taken   (branch_taken),
      .branch_offset  (branch_offset),
      .running        (running),
      .accepted_count (accepted_count)
   );

   always #5 clk = ~clk;

   // program_counter model: pc <= pc + 1 + (jump_offset & pc_control), no reset.
   always @(posedge clk) begin
      if (pc_load) pc <= pc_load_val;
      else         pc <= pc + 8'd1 + (jump_offset & pc_control);
   end

   // Scoreboard monitor: compare every accepted instruction.
   always @(negedge clk) begin
      logic [16:0] exp_e;
      if (rst_n && instr_valid && decode_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got pc=%0h instr=%0h, expected nothing", instr_pc, instr);
         end else begin
            exp_e = sb.pop_front();
            if ({instr_pc, instr} !== exp_e) begin
               errors++;
               $display("FAIL sb_fetch: got pc=%0h instr=%0h, expected pc=%0h instr=%0h",
                        instr_pc, instr, exp_e[16:9], exp_e[8:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pc(input logic [7:0] v);
      pc_load     = 1'b1;
      pc_load_val = v;
      tick();
      pc_load     = 1'b0;
   endtask

   task automatic load(input logic [7:0] a, input logic [8:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      tick();
      prog_we   = 1'b0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic push(input logic [7:0] p, input logic [8:0] d);
      sb.push_back({p, d});
   endtask

   task automatic run_until_halt(output bit timed_out);
      timed_out = 1'b1;
      for (int c = 0; c < 60; c++) begin
         if (!running) begin
            timed_out = 1'b0;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      decode_ready = 1'b0;
      branch_taken = 1'b0;
      rst_n = 1'b0;
      sb.delete();
      tick();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", instr_valid); end
      checks++; if (instr !== 9'h000) begin errors++; $display("FAIL rst_instr: got %0h expected 0", instr); end
      checks++; if (instr_pc !== 8'h00) begin errors++; $display("FAIL rst_instr_pc: got %0h expected 0", instr_pc); end
      checks++; if (accepted_count !== 16'h0) begin errors++; $display("FAIL rst_count: got %0h expected 0", accepted_count); end
      checks++; if (pc_control !== 8'hFF) begin errors++; $display("FAIL rst_pc_control: got %0h expected ff", pc_control); end
      checks++; if (jump_offset !== 8'hFF) begin errors++; $display("FAIL rst_jump_offset: got %0h expected ff", jump_offset); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running: got %0b expected 0", running); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      bit to;
      set_pc(8'h00);
      load(8'd0, 9'd1); load(8'd1, 9'd2); load(8'd2, 9'd3); load(8'd3, 9'h1FF);
      push(8'd0, 9'd1); push(8'd1, 9'd2); push(8'd2, 9'd3); push(8'd3, 9'h1FF);
      decode_ready = 1'b1;
      start_pulse();
      run_until_halt(to);
      checks++; if (to) begin errors++; $display("FAIL basic_halt: got running=%0b expected 0", running); end
      tick(); tick();
      checks++; if (pc !== 8'd4) begin errors++; $display("FAIL basic_pc: got %0h expected 4", pc); end
      checks++; if (accepted_count !== 16'd4) begin errors++; $display("FAIL basic_count: got %0d expected 4", accepted_count); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_valid: got %0b expected 0", instr_valid); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL basic_sb: got %0d left expected 0", sb.size()); end
   endtask

   task automatic test_stall();
      bit to;
      bit seen;
      test_reset();
      set_pc(8'h00);
      push(8'd0, 9'd1); push(8'd1, 9'd2); push(8'd2, 9'd3); push(8'd3, 9'h1FF);
      decode_ready = 1'b1;
      start_pulse();
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (instr_valid && instr == 9'd2) begin seen = 1'b1; break; end
         tick();
      end
      checks++; if (!seen) begin errors++; $display("FAIL stall_reach: got no instr 2 expected instr 2"); end
      decode_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (instr !== 9'd2 || instr_pc !== 8'd1 || pc !== 8'd2 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: got instr=%0h instr_pc=%0h pc=%0h expected 2/1/2", instr, instr_pc, pc);
         end
         tick();
      end
      decode_ready = 1'b1;
      tick();
      checks++; if (instr !== 9'd3 || instr_pc !== 8'd2) begin errors++; $display("FAIL stall_release: got %0h/%0h expected 3/2", instr, instr_pc); end
      run_until_halt(to);
      checks++; if (to) begin errors++; $display("FAIL stall_halt: got running=%0b expected 0", running); end
      checks++; if (accepted_count !== 16'd4) begin errors++; $display("FAIL stall_count: got %0d expected 4", accepted_count); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL stall_sb: got %0d left expected 0", sb.size()); end
   endtask

   task automatic test_branch_fwd();
      bit to;
      bit done;
      test_reset();
      set_pc(8'h00);
      for (int i = 0; i < 6; i++) begin
         load(8'(i), 9'h040 + 9'(i));
         push(8'(i), 9'h040 + 9'(i));
      end
      load(8'd16, 9'h1FF);
      push(8'd16, 9'h1FF);
      decode_ready = 1'b1;
      start_pulse();
      done = 1'b0;
      for (int c = 0; c < 40 && running; c++) begin
         if (!done && instr_valid && instr_pc == 8'd5) begin
            branch_taken  = 1'b1;
            branch_offset = 8'h0A;
            #1;
            checks++; if (jump_offset !== 8'h09) begin errors++; $display("FAIL fwd_jump_offset: got %0h expected 09", jump_offset); end
            checks++; if (pc_control !== 8'hFF || pc !== 8'd6) begin errors++; $display("FAIL fwd_ctl_pc: got ctl=%0h pc=%0h expected ff/6", pc_control, pc); end
            tick();
            branch_taken = 1'b0;
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fwd_bubble: got %0b expected 0", instr_valid); end
            checks++; if (pc !== 8'd16) begin errors++; $display("FAIL fwd_target: got %0h expected 10", pc); end
            done = 1'b1;
         end else begin
            tick();
         end
      end
      branch_taken = 1'b0;
      checks++; if (!done || running) begin errors++; $display("FAIL fwd_done: got done=%0b running=%0b expected 1/0", done, running); end
      checks++; if (accepted_count !== 16'd7) begin errors++; $display("FAIL fwd_count: got %0d expected 7", accepted_count); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL fwd_sb: got %0d left expected 0", sb.size()); end
   endtask

   task automatic test_branch_back();
      bit done;
      test_reset();
      set_pc(8'h01);
      load(8'd1, 9'h031); load(8'd2, 9'h032); load(8'd255, 9'h033); load(8'd0, 9'h1FF);
      push(8'd1, 9'h031); push(8'd2, 9'h032); push(8'd255, 9'h033); push(8'd0, 9'h1FF);
      decode_ready = 1'b1;
      start_pulse();
      done = 1'b0;
      for (int c = 0; c < 40 && running; c++) begin
         if (!done && instr_valid && instr_pc == 8'd2) begin
            branch_taken  = 1'b1;
            branch_offset = 8'hFC;
            #1;
            checks++; if (jump_offset !== 8'hFB || pc !== 8'd3) begin errors++; $display("FAIL back_jump_offset: got %0h pc=%0h expected fb/3", jump_offset, pc); end
            tick();
            branch_taken = 1'b0;
            checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL back_target: got %0h expected ff", pc); end
            done = 1'b1;
         end else begin
            tick();
         end
      end
      branch_taken = 1'b0;
      checks++; if (!done || running) begin errors++; $display("FAIL back_done: got done=%0b running=%0b expected 1/0", done, running); end
      checks++; if (pc !== 8'd1) begin errors++; $display("FAIL back_wrap_pc: got %0h expected 1", pc); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL back_sb: got %0d left expected 0", sb.size()); end
   endtask

   task automatic test_reset_mid_run();
      bit seen;
      test_reset();
      set_pc(8'h00);
      load(8'd0, 9'd1); load(8'd1, 9'd2); load(8'd2, 9'd3); load(8'd3, 9'h1FF);
      push(8'd0, 9'd1);
      decode_ready = 1'b1;
      start_pulse();
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (accepted_count == 16'd1) begin seen = 1'b1; break; end
         tick();
      end
      decode_ready = 1'b0;
      checks++; if (!seen || instr_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got seen=%0b valid=%0b expected 1/1", seen, instr_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b expected 0", instr_valid); end
      checks++; if (accepted_count !== 16'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", accepted_count); end
      checks++; if (pc_control !== 8'hFF) begin errors++; $display("FAIL mid_pc_control: got %0h expected ff", pc_control); end
      sb.delete();
      tick();
      rst_n = 1'b1;
      decode_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks++; if (pc !== 8'd2 || instr_valid !== 1'b0 || running !== 1'b0) begin
         errors++; $display("FAIL mid_idle: got pc=%0h valid=%0b running=%0b expected 2/0/0", pc, instr_valid, running);
      end
   endtask

   task automatic test_prog_we();
      bit to;
      bit wrote;
      test_reset();
      set_pc(8'h00);
      load(8'd0, 9'h021); load(8'd1, 9'h022); load(8'd2, 9'h1FF);
      push(8'd0, 9'h021); push(8'd1, 9'h022); push(8'd2, 9'h1FF);
      decode_ready = 1'b1;
      start_pulse();
      wrote = 1'b0;
      for (int c = 0; c < 30 && running; c++) begin
         if (!wrote && pc == 8'd1) begin
            prog_we = 1'b1; prog_addr = 8'd2; prog_data = 9'h0AA;
            tick();
            prog_we = 1'b0;
            wrote = 1'b1;
         end else begin
            tick();
         end
      end
      checks++; if (!wrote || running) begin errors++; $display("FAIL we_run_done: got wrote=%0b running=%0b expected 1/0", wrote, running); end
      checks++; if (pc !== 8'd3) begin errors++; $display("FAIL we_run_pc: got %0h expected 3", pc); end
      load(8'd2, 9'h0AA); load(8'd3, 9'h1FF);
      set_pc(8'd2);
      push(8'd2, 9'h0AA); push(8'd3, 9'h1FF);
      start_pulse();
      run_until_halt(to);
      checks++; if (to) begin errors++; $display("FAIL we_halt_run: got running=%0b expected 0", running); end
      checks++; if (accepted_count !== 16'd5) begin errors++; $display("FAIL we_count: got %0d expected 5", accepted_count); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL we_sb: got %0d left expected 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_branch_fwd();
      test_branch_back();
      test_reset_mid_run();
      test_prog_we();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly downstream of the 8-bit program counter. It consumes `pc` and reads the instruction at that address from an internal instruction memory.
- It presents the instruction to decode through a valid/ready instruction register.
- It steers the counter by driving its `pc_control` and `jump_offset` inputs:
  - hold: offset -1, so pc + 1 - 1 = pc
  - branch redirect
  - normal increment
- It also handles program load, start, halt, and an accepted-instruction counter.

Parameters:
- INSTR_W, 9, instruction width in bits.
- DEPTH, 256, instruction memory words; fully addressed by the 8-bit pc.
- HALT_INSTR, 9'h1FF, encoding that stops fetch once decode accepts it.

Ports:
- clk  input  1  rising-edge clock shared with program_counter.
- rst_n  input  1  asynchronous active-low reset.
- pc  input  8  current address from program_counter.
- pc_control  output  8  mask to program_counter; 8'h00 = increment, 8'hFF = use jump_offset.
- jump_offset  output  8  offset to program_counter.
- start  input  1  single-cycle pulse; leaves IDLE or HALT.
- prog_we  input  1  instruction memory write enable.
- prog_addr  input  8  write address.
- prog_data  input  INSTR_W  write data.
- instr  output  INSTR_W  instruction register to decode.
- instr_pc  output  8  address instr was fetched from.
- instr_valid  output  1  instr/instr_pc valid.
- decode_ready  input  1  decode accepts instr this cycle.
- branch_taken  input  1  decode: the accepted instr is a taken branch.
- branch_offset  input  8  two's-complement offset; target = instr_pc + 1 + branch_offset.
- running  output  1  high in RUN.
- accepted_count  output  16  instructions accepted by decode since reset.

Behaviour:
- **Reset** (rst_n low, asynchronous):
  - state = IDLE; instr = 0, instr_pc = 0, instr_valid = 0, accepted_count = 0.
  - pc_control = 8'hFF, jump_offset = 8'hFF (hold).
  - Memory contents are not reset.
- **Accept** = instr_valid & decode_ready. branch_taken is ignored unless accept.
- **Memory:** read is combinational on pc; writes are synchronous.
  - prog_we honoured only in IDLE or HALT; ignored in RUN.
  - A write to address pc in the same cycle is not visible until the next cycle.
- **States:** IDLE, RUN, HALT.
  - IDLE: hold PC, instr_valid = 0; start -> RUN.
  - RUN: fetch per the priority list below.
  - HALT: identical to IDLE (hold, valid 0, loads allowed); start -> RUN, resuming at the current pc.
- **RUN priority each cycle** (outputs combinational from state and inputs; registers update at the edge):
  1. Redirect (accept & branch_taken):
     - pc_control = 8'hFF; jump_offset = (instr_pc + 1 + branch_offset) - pc - 1, computed mod 256.
     - instr_valid <= 0 (flush the wrong-path word); exactly one bubble.
     - The branch is counted as accepted.
  2. Halt (accept & instr == HALT_INSTR & !branch_taken):
     - Hold the PC; instr_valid <= 0; state <= HALT.
     - The halt word counts as accepted.
  3. Stall (instr_valid & !decode_ready):
     - Hold the PC; instr/instr_pc/instr_valid unchanged and stable.
  4. Fetch (otherwise):
     - pc_control = 8'h00; instr <= mem[pc]; instr_pc <= pc; instr_valid <= 1.
     - program_counter advances to pc + 1.
- **start:** ignored while in RUN. start in the same cycle as a halting accept: halt wins; a later start is required.
- **Wrap-around:** pc 8'hFF increments to 8'h00 with no special handling. Branch targets wrap mod 256.
- **accepted_count:** increments on every accept and saturates at 16'hFFFF.
- **Throughput:** one instruction per cycle when decode_ready is held high. First valid instr appears one cycle after leaving IDLE.
- **Reset mid-RUN:** the pipeline is cleared at once. program_counter keeps its pc (it has no reset) and is held from then on.

Test Plan:
- Load mem[0..3] = 1,2,3,HALT_INSTR; pc starts at 0; pulse start; decode_ready = 1 -> instr 1,2,3,1FF on consecutive cycles with instr_pc 0,1,2,3; then HALT, running = 0, pc holds at 4, accepted_count = 4.
- Same program with decode_ready low for 3 cycles while instr = 2 -> instr/instr_pc hold at 2/1 and pc holds at 2; after release, 3 follows on the next cycle.
- Accept at instr_pc = 5 with branch_taken and branch_offset = 8'h0A (target 16), pc = 6 -> jump_offset = 8'h09; pc becomes 16; one cycle instr_valid = 0; next instr_pc = 16.
- Backward branch at instr_pc = 2 with branch_offset = 8'hFC (target 255), pc = 3 -> jump_offset = 8'hFB; pc becomes 255; the following fetch wraps to pc = 0.
- Assert rst_n low mid-RUN with instr_valid = 1 -> immediately instr_valid = 0, accepted_count = 0, pc_control = 8'hFF; no fetch until start.
- prog_we in RUN to the next fetch address -> memory unchanged and the original word is fetched; the same write in HALT takes effect.
